// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, size and owner codes for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: byte enables, write-lane replication, misalign flag and read-data alignment for a 4-lane bus
module mem_lane_steer
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] mem_wdata,
  output logic        misalign,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  always_comb begin
    sh = mem_rdata >> {off, 3'b000};
    misalign = size == 2'b11 || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    be = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : size == SZ_WORD ? 4'b1111 : 4'b0000;
    mem_wdata = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == SZ_BYTE ? {24'd0, sh[7:0]} : size == SZ_HALF ? {16'd0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin CPU/DMA arbiter onto a single-port memory with lane steering and timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [1:0]        iCpuSize,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWData,
  output logic              oCpuDone,
  output logic [DATA_W-1:0] oCpuRData,
  output logic              oCpuErr,
  input  logic              iDmaReq,
  input  logic              iDmaWe,
  input  logic [1:0]        iDmaSize,
  input  logic [ADDR_W-1:0] iDmaAddr,
  input  logic [DATA_W-1:0] iDmaWData,
  output logic              oDmaDone,
  output logic [DATA_W-1:0] oDmaRData,
  output logic              oDmaErr,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [3:0]        oMemBE,
  output logic [DATA_W-1:0] oMemWData,
  input  logic              iMemAck,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oBusy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  owner_t owner_q, owner_d, last_q, last_d;
  logic we_q, we_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cpu_win, sel_we, misalign, acc, cpu_done, dma_done;
  logic [1:0] sel_size, st_size, st_off;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, st_wdata, st_rdata;
  logic [3:0] st_be;
  assign cpu_win   = iCpuReq && (!iDmaReq || last_q == OWN_DMA);
  assign sel_we    = cpu_win ? iCpuWe : iDmaWe;
  assign sel_size  = cpu_win ? iCpuSize : iDmaSize;
  assign sel_addr  = cpu_win ? iCpuAddr : iDmaAddr;
  assign sel_wdata = cpu_win ? iCpuWData : iDmaWData;
  assign st_size   = state_q == ST_IDLE ? sel_size : size_q;
  assign st_off    = state_q == ST_IDLE ? sel_addr[1:0] : addr_q[1:0];
  mem_lane_steer u_steer (
    .size(st_size),
    .off(st_off),
    .wdata(wdata_q),
    .mem_rdata(iMemRData),
    .be(st_be),
    .mem_wdata(st_wdata),
    .misalign(misalign),
    .rdata(st_rdata)
  );
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (iCpuReq || iDmaReq) begin
        owner_d = cpu_win ? OWN_CPU : OWN_DMA;
        we_d    = sel_we;
        size_d  = sel_size;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = misalign;
        state_d = misalign ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: if (iMemAck) begin
        rdata_d = st_rdata;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = ST_RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_DMA;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign acc       = state_q == ST_ACCESS;
  assign cpu_done  = state_q == ST_RESP && owner_q == OWN_CPU;
  assign dma_done  = state_q == ST_RESP && owner_q == OWN_DMA;
  assign oMemReq   = acc;
  assign oMemWe    = acc && we_q;
  assign oMemAddr  = acc ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign oMemBE    = acc ? st_be : 4'b0000;
  assign oMemWData = acc ? st_wdata : '0;
  assign oCpuDone  = cpu_done;
  assign oCpuRData = cpu_done ? rdata_q : '0;
  assign oCpuErr   = cpu_done && err_q;
  assign oDmaDone  = dma_done;
  assign oDmaRData = dma_done ? rdata_q : '0;
  assign oDmaErr   = dma_done && err_q;
  assign oBusy     = state_q != ST_IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic iCLK = 1'b0, iRST = 1'b1;
  logic iCpuReq, iCpuWe, iDmaReq, iDmaWe, iMemAck;
  logic [1:0] iCpuSize, iDmaSize;
  logic [31:0] iCpuAddr, iCpuWData, iDmaAddr, iDmaWData, iMemRData;
  logic oCpuDone, oCpuErr, oDmaDone, oDmaErr, oMemReq, oMemWe, oBusy;
  logic [31:0] oCpuRData, oDmaRData, oMemAddr, oMemWData;
  logic [3:0] oMemBE;
  int checks = 0, failures = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuSize(iCpuSize), .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
    .oCpuDone(oCpuDone), .oCpuRData(oCpuRData), .oCpuErr(oCpuErr),
    .iDmaReq(iDmaReq), .iDmaWe(iDmaWe), .iDmaSize(iDmaSize), .iDmaAddr(iDmaAddr), .iDmaWData(iDmaWData),
    .oDmaDone(oDmaDone), .oDmaRData(oDmaRData), .oDmaErr(oDmaErr),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBE(oMemBE), .oMemWData(oMemWData),
    .iMemAck(iMemAck), .iMemRData(iMemRData), .oBusy(oBusy)
  );
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge iCLK);
    #1;
  endtask
  task automatic cpu_go(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    iCpuReq = 1'b1; iCpuWe = we; iCpuSize = sz; iCpuAddr = a; iCpuWData = d;
  endtask
  task automatic dma_go(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    iDmaReq = 1'b1; iDmaWe = we; iDmaSize = sz; iDmaAddr = a; iDmaWData = d;
  endtask
  initial begin
    iCpuReq = 0; iCpuWe = 0; iCpuSize = 0; iCpuAddr = 0; iCpuWData = 0;
    iDmaReq = 0; iDmaWe = 0; iDmaSize = 0; iDmaAddr = 0; iDmaWData = 0;
    iMemAck = 0; iMemRData = 0;
    step; step;
    chk("rst_busy", oBusy, 0);
    chk("rst_memreq", oMemReq, 0);
    chk("rst_cpudone", oCpuDone, 0);
    chk("rst_dmadone", oDmaDone, 0);
    chk("rst_memaddr", oMemAddr, 0);
    iRST = 1'b0;
    step;
    cpu_go(0, 2'b10, 32'h104, 0);
    step;
    chk("wr_acc_req", oMemReq, 1);
    chk("wr_acc_addr", oMemAddr, 32'h104);
    chk("wr_acc_be", oMemBE, 4'b1111);
    chk("wr_acc_we", oMemWe, 0);
    chk("wr_acc_busy", oBusy, 1);
    chk("wr_acc_nodone", oCpuDone, 0);
    iMemAck = 1; iMemRData = 32'hDEADBEEF;
    step;
    chk("wr_done", oCpuDone, 1);
    chk("wr_rdata", oCpuRData, 32'hDEADBEEF);
    chk("wr_err", oCpuErr, 0);
    chk("wr_dma_quiet", oDmaDone, 0);
    chk("wr_resp_memreq", oMemReq, 0);
    iCpuReq = 0; iMemAck = 0;
    step;
    chk("wr_idle_done", oCpuDone, 0);
    chk("wr_idle_busy", oBusy, 0);
    cpu_go(1, 2'b00, 32'h203, 32'h000000A5);
    step;
    chk("bw_addr", oMemAddr, 32'h200);
    chk("bw_be", oMemBE, 4'b1000);
    chk("bw_wdata", oMemWData, 32'hA5A5A5A5);
    chk("bw_we", oMemWe, 1);
    iCpuAddr = 0; iCpuWData = 0; iCpuSize = 2'b10;
    step;
    chk("bw_hold_addr", oMemAddr, 32'h200);
    chk("bw_hold_wdata", oMemWData, 32'hA5A5A5A5);
    chk("bw_hold_be", oMemBE, 4'b1000);
    iMemAck = 1;
    step;
    chk("bw_done", oCpuDone, 1);
    chk("bw_err", oCpuErr, 0);
    iCpuReq = 0; iMemAck = 0;
    step;
    cpu_go(0, 2'b01, 32'h202, 0);
    step;
    chk("hr_addr", oMemAddr, 32'h200);
    chk("hr_be", oMemBE, 4'b1100);
    iMemAck = 1; iMemRData = 32'h12345678;
    step;
    chk("hr_rdata", oCpuRData, 32'h00001234);
    iCpuReq = 0; iMemAck = 0;
    step;
    cpu_go(0, 2'b00, 32'h201, 0);
    step;
    chk("br_be", oMemBE, 4'b0010);
    iMemAck = 1; iMemRData = 32'hDEADBEEF;
    step;
    chk("br_rdata", oCpuRData, 32'h000000BE);
    iCpuReq = 0; iMemAck = 0;
    step;
    cpu_go(0, 2'b10, 32'h101, 0);
    step;
    chk("mis_done", oCpuDone, 1);
    chk("mis_err", oCpuErr, 1);
    chk("mis_memreq", oMemReq, 0);
    chk("mis_rdata", oCpuRData, 0);
    iCpuReq = 0;
    step;
    chk("mis_idle", oBusy, 0);
    cpu_go(0, 2'b11, 32'h100, 0);
    step;
    chk("ill_done", oCpuDone, 1);
    chk("ill_err", oCpuErr, 1);
    chk("ill_memreq", oMemReq, 0);
    iCpuReq = 0;
    step;
    cpu_go(0, 2'b10, 32'h300, 0);
    step;
    chk("rst_mid_req", oMemReq, 1);
    iMemAck = 1; iMemRData = 32'h55555555;
    #2;
    iRST = 1'b1;
    #1;
    chk("rst_mid_memreq", oMemReq, 0);
    chk("rst_mid_busy", oBusy, 0);
    chk("rst_mid_nodone", oCpuDone, 0);
    step;
    chk("rst_mid_nodone2", oCpuDone, 0);
    iMemAck = 0; iCpuReq = 0; iRST = 1'b0;
    step;
    cpu_go(0, 2'b10, 32'h10, 0);
    dma_go(0, 2'b10, 32'h20, 0);
    for (int k = 0; k < 4; k++) begin
      step;
      chk($sformatf("rr%0d_addr", k), oMemAddr, (k % 2 == 0) ? 32'h10 : 32'h20);
      iMemAck = 1;
      step;
      chk($sformatf("rr%0d_cpudone", k), oCpuDone, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_dmadone", k), oDmaDone, (k % 2 == 0) ? 0 : 1);
      iMemAck = 0;
      step;
    end
    iCpuReq = 0; iDmaReq = 0;
    step;
    dma_go(0, 2'b10, 32'h40, 0);
    iMemRData = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("to_req%0d", i), oMemReq, 1);
    end
    step;
    chk("to_memreq_drop", oMemReq, 0);
    chk("to_done", oDmaDone, 1);
    chk("to_err", oDmaErr, 1);
    chk("to_rdata", oDmaRData, 0);
    chk("to_cpu_quiet", oCpuDone, 0);
    iDmaReq = 0;
    step;
    dma_go(0, 2'b10, 32'h44, 0);
    step; step; step; step;
    chk("tb_last_req", oMemReq, 1);
    iMemAck = 1; iMemRData = 32'h0BADF00D;
    step;
    chk("tb_done", oDmaDone, 1);
    chk("tb_err", oDmaErr, 0);
    chk("tb_rdata", oDmaRData, 32'h0BADF00D);
    iDmaReq = 0; iMemAck = 0;
    step;
    chk("end_idle", oBusy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
